// File: rtl/gaplus_vmem_server_if.sv
// Bus bundle between the Gaplus video/CPU side and the VRAM server.
//   ce_pix          : pixel strobe; the cycle it is high is slot 0
//   vram_a / vram_d : video tile address / tile word {attr, code}
//   spra_a / spra_d : video sprite attribute address / word {bank2, bank1, bank0}
//   cpu_req/cpu_we/cpu_ad/cpu_di : CPU request, held until cpu_ack
//   cpu_do / cpu_ack: CPU read data and one-cycle completion pulse
// master = video engine + CPU side, slave = the memory server.
interface gaplus_vmem_server_if #(
    parameter int VRAM_AW = 11,
    parameter int SPRA_AW = 7,
    parameter int CPU_AW  = 13
);
    logic               ce_pix;
    logic [VRAM_AW-1:0] vram_a;
    logic [15:0]        vram_d;
    logic [SPRA_AW-1:0] spra_a;
    logic [23:0]        spra_d;
    logic               cpu_req;
    logic               cpu_we;
    logic [CPU_AW-1:0]  cpu_ad;
    logic [7:0]         cpu_di;
    logic [7:0]         cpu_do;
    logic               cpu_ack;

    modport master (
        output ce_pix, vram_a, spra_a, cpu_req, cpu_we, cpu_ad, cpu_di,
        input  vram_d, spra_d, cpu_do, cpu_ack
    );

    modport slave (
        input  ce_pix, vram_a, spra_a, cpu_req, cpu_we, cpu_ad, cpu_di,
        output vram_d, spra_d, cpu_do, cpu_ack
    );
endinterface

// File: rtl/gaplus_vmem_server.sv
// Gaplus video memory server: tile VRAM (2K x 16, two byte lanes) and sprite
// attribute RAM (128 x 24, three byte banks). Each pixel period is split into
// four slots so the single-ported banks are never contended:
//   slot 0: latch video addresses, slot 1: register video read data,
//   slot 2: perform the pending CPU byte access (ACK/CPU_DO visible in slot 3).
// Ports:
//   clk_i  : 4x pixel clock
//   rst_i  : asynchronous active-high reset (RAM contents are kept)
//   bus_if : slave side of gaplus_vmem_server_if (video + CPU handshake)
module gaplus_vmem_server #(
    parameter int VRAM_AW = 11,
    parameter int SPRA_AW = 7,
    parameter int CPU_AW  = 13
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    gaplus_vmem_server_if.slave   bus_if
);
    localparam logic [1:0] SLOT0 = 2'd0;
    localparam logic [1:0] SLOT1 = 2'd1;
    localparam logic [1:0] SLOT2 = 2'd2;

    // Word layout: vram [1]=attr [0]=code; sprite [2:0] = bank2..bank0.
    logic [1:0][7:0] vram_mem [2**VRAM_AW];
    logic [2:0][7:0] spr_mem  [2**SPRA_AW];

    logic [1:0]         slot_cnt_q, slot_cnt_d, slot;
    logic [VRAM_AW-1:0] va_q;
    logic [SPRA_AW-1:0] sa_q;
    logic [15:0]        vram_d_q;
    logic [23:0]        spra_d_q;
    logic               pend_q, pend_we_q, ack_q;
    logic [CPU_AW-1:0]  pend_ad_q;
    logic [7:0]         pend_di_q, cpu_do_q, cpu_rdata;
    logic               capture, serve, is_spr, lane;
    logic [1:0]         bank;
    logic [VRAM_AW-1:0] cpu_va;
    logic [SPRA_AW-1:0] cpu_sa;

    // CE_PIX forces the current cycle to slot 0 even mid-sequence.
    assign slot       = bus_if.ce_pix ? SLOT0 : slot_cnt_q;
    assign slot_cnt_d = slot + 2'd1;

    // ack_q blocks recapturing a request still held high in its ACK cycle.
    assign capture = bus_if.cpu_req && !pend_q && !ack_q;
    assign serve   = pend_q && (slot == SLOT2);

    assign is_spr = pend_ad_q[12];
    assign lane   = pend_ad_q[11];
    assign bank   = pend_ad_q[8:7];
    assign cpu_va = pend_ad_q[VRAM_AW-1:0];
    assign cpu_sa = pend_ad_q[SPRA_AW-1:0];

    // Byte read for the pending CPU access; bank 3 is unmapped and reads 0xFF.
    always_comb begin
        cpu_rdata = 8'hFF;
        if (!is_spr) begin
            cpu_rdata = vram_mem[cpu_va][lane];
        end else begin
            case (bank)
                2'd0:    cpu_rdata = spr_mem[cpu_sa][0];
                2'd1:    cpu_rdata = spr_mem[cpu_sa][1];
                2'd2:    cpu_rdata = spr_mem[cpu_sa][2];
                default: cpu_rdata = 8'hFF;
            endcase
        end
    end

    // RAM write port: single byte lane, slot 2 only; bank 3 writes are dropped.
    always_ff @(posedge clk_i) begin
        if (serve && pend_we_q) begin
            if (!is_spr) begin
                vram_mem[cpu_va][lane] <= pend_di_q;
            end else begin
                case (bank)
                    2'd0:    spr_mem[cpu_sa][0] <= pend_di_q;
                    2'd1:    spr_mem[cpu_sa][1] <= pend_di_q;
                    2'd2:    spr_mem[cpu_sa][2] <= pend_di_q;
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            slot_cnt_q <= SLOT0;
            va_q       <= '0;
            sa_q       <= '0;
            vram_d_q   <= '0;
            spra_d_q   <= '0;
            pend_q     <= 1'b0;
            pend_we_q  <= 1'b0;
            pend_ad_q  <= '0;
            pend_di_q  <= '0;
            cpu_do_q   <= '0;
            ack_q      <= 1'b0;
        end else begin
            slot_cnt_q <= slot_cnt_d;
            ack_q      <= 1'b0;
            if (capture) begin
                pend_q    <= 1'b1;
                pend_we_q <= bus_if.cpu_we;
                pend_ad_q <= bus_if.cpu_ad;
                pend_di_q <= bus_if.cpu_di;
            end
            if (slot == SLOT0) begin
                va_q <= bus_if.vram_a;
                sa_q <= bus_if.spra_a;
            end
            // Runs before the slot-2 CPU write, so a same-word write shows next sequence.
            if (slot == SLOT1) begin
                vram_d_q <= vram_mem[va_q];
                spra_d_q <= spr_mem[sa_q];
            end
            // Completion is registered at the slot-2 edge so ACK/CPU_DO are seen in slot 3.
            if (serve) begin
                pend_q <= 1'b0;
                ack_q  <= 1'b1;
                if (!pend_we_q) cpu_do_q <= cpu_rdata;
            end
        end
    end

    assign bus_if.vram_d  = vram_d_q;
    assign bus_if.spra_d  = spra_d_q;
    assign bus_if.cpu_do  = cpu_do_q;
    assign bus_if.cpu_ack = ack_q;
endmodule

// File: tb/tb_gaplus_vmem_server.sv
module tb_gaplus_vmem_server;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk  = 0;
    int   n_fail = 0;
    int   tb_slot = 0;
    int   tb_cnt  = 0;

    gaplus_vmem_server_if #(.VRAM_AW(11), .SPRA_AW(7), .CPU_AW(13)) bus_if ();

    gaplus_vmem_server #(.VRAM_AW(11), .SPRA_AW(7), .CPU_AW(13)) dut (
        .clk_i  (clk),
        .rst_i  (rst),
        .bus_if (bus_if)
    );

    always #5 clk = ~clk;

    // Move to the next cycle's negedge and drive CE_PIX for that cycle.
    task automatic adv(input bit ce);
        @(negedge clk);
        bus_if.ce_pix = ce;
        tb_slot = ce ? 0 : tb_cnt;
        tb_cnt  = (tb_slot + 1) % 4;
    endtask

    task automatic adv_norm();
        adv(tb_cnt == 0);
    endtask

    task automatic wait_slot(input int s);
        for (int i = 0; i < 8; i++) begin
            adv_norm();
            if (tb_slot == s) break;
        end
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst = 1'b0;
        bus_if.ce_pix = 1'b1;
        tb_slot = 0;
        tb_cnt  = 1;
    endtask

    // Issue one access and wait (bounded) for ACK; lat = cycles to ACK, -1 on timeout.
    task automatic cpu_acc(input bit we, input logic [12:0] ad, input logic [7:0] di,
                           output logic [7:0] d, output int lat);
        bus_if.cpu_req = 1'b1;
        bus_if.cpu_we  = we;
        bus_if.cpu_ad  = ad;
        bus_if.cpu_di  = di;
        lat = -1;
        d   = 8'h00;
        for (int i = 1; i <= 12; i++) begin
            adv_norm();
            if (bus_if.cpu_ack === 1'b1) begin
                lat = i;
                d   = bus_if.cpu_do;
                break;
            end
        end
        bus_if.cpu_req = 1'b0;
    endtask

    task automatic test_reset();
        int acks;
        n_chk++;
        if ({bus_if.vram_d, bus_if.spra_d, bus_if.cpu_do, bus_if.cpu_ack} !== 49'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h/%h/%h/%b want 0", bus_if.vram_d, bus_if.spra_d,
                     bus_if.cpu_do, bus_if.cpu_ack);
        end
        release_reset();
        // Write captured in slot 0, pending in slot 1, reset lands in slot 2.
        bus_if.cpu_req = 1'b1; bus_if.cpu_we = 1'b1; bus_if.cpu_ad = 13'h0300; bus_if.cpu_di = 8'h11;
        adv_norm();
        adv_norm();
        rst = 1'b1;
        #1;
        acks = 0;
        n_chk++;
        if ({bus_if.vram_d, bus_if.spra_d, bus_if.cpu_do, bus_if.cpu_ack} !== 49'd0) begin
            n_fail++;
            $display("FAIL reset_mid_access_outputs: got %h/%h/%h/%b want 0", bus_if.vram_d,
                     bus_if.spra_d, bus_if.cpu_do, bus_if.cpu_ack);
        end
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            if (bus_if.cpu_ack !== 1'b0) acks++;
        end
        bus_if.cpu_req = 1'b0;
        release_reset();
        for (int i = 0; i < 8; i++) begin
            adv_norm();
            if (bus_if.cpu_ack !== 1'b0) acks++;
        end
        n_chk++;
        if (acks !== 0) begin
            n_fail++;
            $display("FAIL reset_no_ack: got %0d ack cycles want 0", acks);
        end
    endtask

    task automatic test_vram_lanes();
        logic [7:0] d;
        int lat;
        cpu_acc(1'b1, 13'h0123, 8'h5A, d, lat);
        cpu_acc(1'b1, 13'h0923, 8'hA5, d, lat);
        n_chk++;
        if (lat < 0) begin
            n_fail++;
            $display("FAIL vram_write_ack: got timeout want ack");
        end
        wait_slot(3);
        bus_if.vram_a = 11'h123;
        wait_slot(2);
        n_chk++;
        if (bus_if.vram_d !== 16'hA55A) begin
            n_fail++;
            $display("FAIL vram_word: got %h want a55a", bus_if.vram_d);
        end
        cpu_acc(1'b0, 13'h0923, 8'h00, d, lat);
        n_chk++;
        if (lat < 0 || d !== 8'hA5) begin
            n_fail++;
            $display("FAIL vram_read_attr: got %h lat %0d want a5", d, lat);
        end
        cpu_acc(1'b0, 13'h0123, 8'h00, d, lat);
        n_chk++;
        if (lat < 0 || d !== 8'h5A) begin
            n_fail++;
            $display("FAIL vram_read_code: got %h lat %0d want 5a", d, lat);
        end
    endtask

    task automatic test_sprite_banks();
        logic [7:0] d;
        int lat;
        cpu_acc(1'b1, 13'h1005, 8'h11, d, lat);
        cpu_acc(1'b1, 13'h1085, 8'h22, d, lat);
        cpu_acc(1'b1, 13'h1105, 8'h33, d, lat);
        bus_if.spra_a = 7'h05;
        wait_slot(3);
        wait_slot(2);
        n_chk++;
        if (bus_if.spra_d !== 24'h332211) begin
            n_fail++;
            $display("FAIL spra_word: got %h want 332211", bus_if.spra_d);
        end
        cpu_acc(1'b0, 13'h1185, 8'h00, d, lat);
        n_chk++;
        if (lat < 0 || d !== 8'hFF) begin
            n_fail++;
            $display("FAIL spra_bank3_read: got %h lat %0d want ff", d, lat);
        end
        cpu_acc(1'b1, 13'h1185, 8'h99, d, lat);
        wait_slot(3);
        wait_slot(2);
        n_chk++;
        if (lat < 0 || bus_if.spra_d !== 24'h332211) begin
            n_fail++;
            $display("FAIL spra_unchanged: got %h lat %0d want 332211", bus_if.spra_d, lat);
        end
        cpu_acc(1'b0, 13'h1E85, 8'h00, d, lat);
        n_chk++;
        if (lat < 0 || d !== 8'h22) begin
            n_fail++;
            $display("FAIL spra_ignored_bits: got %h lat %0d want 22", d, lat);
        end
    endtask

    task automatic test_handshake();
        logic [7:0] d;
        int lat, acks, l2;
        wait_slot(3);
        bus_if.cpu_req = 1'b1; bus_if.cpu_we = 1'b1; bus_if.cpu_ad = 13'h0200; bus_if.cpu_di = 8'h77;
        lat = -1;
        acks = 0;
        for (int i = 1; i <= 14; i++) begin
            adv_norm();
            if (bus_if.cpu_ack === 1'b1) begin
                acks++;
                if (lat < 0) lat = i;
            end
            if (lat > 0 && i == lat + 1) bus_if.cpu_req = 1'b0;
        end
        bus_if.cpu_req = 1'b0;
        n_chk++;
        if (lat !== 4) begin
            n_fail++;
            $display("FAIL hs_latency: got %0d want 4", lat);
        end
        n_chk++;
        if (acks !== 1) begin
            n_fail++;
            $display("FAIL hs_single_ack: got %0d want 1", acks);
        end
        cpu_acc(1'b0, 13'h0200, 8'h00, d, l2);
        n_chk++;
        if (l2 < 0 || d !== 8'h77) begin
            n_fail++;
            $display("FAIL hs_readback: got %h lat %0d want 77", d, l2);
        end
    endtask

    task automatic test_lane_isolation();
        logic [7:0] d;
        int lat;
        cpu_acc(1'b1, 13'h0000, 8'hEF, d, lat);
        cpu_acc(1'b1, 13'h0800, 8'hBE, d, lat);
        wait_slot(3);
        bus_if.vram_a = 11'h000;
        wait_slot(2);
        n_chk++;
        if (bus_if.vram_d !== 16'hBEEF) begin
            n_fail++;
            $display("FAIL lane_setup: got %h want beef", bus_if.vram_d);
        end
        cpu_acc(1'b1, 13'h0800, 8'h00, d, lat);
        wait_slot(3);
        wait_slot(2);
        n_chk++;
        if (bus_if.vram_d !== 16'h00EF) begin
            n_fail++;
            $display("FAIL lane_word: got %h want 00ef", bus_if.vram_d);
        end
        cpu_acc(1'b0, 13'h0000, 8'h00, d, lat);
        n_chk++;
        if (lat < 0 || d !== 8'hEF) begin
            n_fail++;
            $display("FAIL lane_code_kept: got %h lat %0d want ef", d, lat);
        end
    endtask

    task automatic test_ce_irregular();
        int early;
        wait_slot(3);
        bus_if.vram_a = 11'h123;
        adv_norm();                                  // slot 0: samples 0x123
        bus_if.cpu_req = 1'b1; bus_if.cpu_we = 1'b0; bus_if.cpu_ad = 13'h0123; bus_if.cpu_di = 8'h00;
        adv_norm();                                  // slot 1: registers A55A, request pending
        bus_if.vram_a = 11'h000;
        adv(1'b1);                                   // would-be slot 2 restarted as slot 0
        early = 0;
        n_chk++;
        if (bus_if.vram_d !== 16'hA55A) begin
            n_fail++;
            $display("FAIL ce_vram_first: got %h want a55a", bus_if.vram_d);
        end
        if (bus_if.cpu_ack !== 1'b0) early++;
        adv_norm();                                  // slot 1
        if (bus_if.cpu_ack !== 1'b0) early++;
        adv_norm();                                  // slot 2: access performed here
        if (bus_if.cpu_ack !== 1'b0) early++;
        n_chk++;
        if (early !== 0) begin
            n_fail++;
            $display("FAIL ce_no_early_ack: got %0d early ack cycles want 0", early);
        end
        adv_norm();                                  // slot 3: ACK
        n_chk++;
        if (bus_if.cpu_ack !== 1'b1 || bus_if.cpu_do !== 8'h5A) begin
            n_fail++;
            $display("FAIL ce_ack_data: got ack %b do %h want 1/5a", bus_if.cpu_ack, bus_if.cpu_do);
        end
        n_chk++;
        if (bus_if.vram_d !== 16'h00EF) begin
            n_fail++;
            $display("FAIL ce_vram_restart: got %h want 00ef", bus_if.vram_d);
        end
        bus_if.cpu_req = 1'b0;
    endtask

    initial begin
        bus_if.ce_pix  = 1'b0;
        bus_if.vram_a  = '0;
        bus_if.spra_a  = '0;
        bus_if.cpu_req = 1'b0;
        bus_if.cpu_we  = 1'b0;
        bus_if.cpu_ad  = '0;
        bus_if.cpu_di  = '0;
        repeat (2) @(negedge clk);
        test_reset();
        test_vram_lanes();
        test_sprite_banks();
        test_handshake();
        test_lane_isolation();
        test_ce_irregular();
        repeat (4) adv_norm();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
